// File: rtl/peripheral_gpio_apb4.sv
// APB4 GPIO register block: pad direction/mode/output control, synchronised
// input view and per-pin level/edge interrupts with W1C status.
module peripheral_gpio_apb4 #(
    parameter int unsigned PADDR_SIZE   = 4,
    parameter int unsigned PDATA_SIZE   = 8,
    parameter int unsigned INPUT_STAGES = 2
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic [PADDR_SIZE-1:0] PADDR,
    input  logic                  PWRITE,
    input  logic                  PSTRB,
    input  logic [PDATA_SIZE-1:0] PWDATA,
    output logic [PDATA_SIZE-1:0] PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR,
    input  logic [PDATA_SIZE-1:0] gpio_i,
    output logic [PDATA_SIZE-1:0] gpio_o,
    output logic [PDATA_SIZE-1:0] gpio_oe,
    output logic                  irq_o
);

    localparam int unsigned SYNC_STAGES = (INPUT_STAGES < 2) ? 2 : INPUT_STAGES;

    localparam logic [2:0] ADDR_MODE      = 3'd0;
    localparam logic [2:0] ADDR_DIRECTION = 3'd1;
    localparam logic [2:0] ADDR_OUTPUT    = 3'd2;
    localparam logic [2:0] ADDR_INPUT     = 3'd3;
    localparam logic [2:0] ADDR_IRQ_ENA   = 3'd4;
    localparam logic [2:0] ADDR_TR_TYPE   = 3'd5;
    localparam logic [2:0] ADDR_TR_POL    = 3'd6;
    localparam logic [2:0] ADDR_TR_STATUS = 3'd7;

    logic [PDATA_SIZE-1:0] mode_reg;
    logic [PDATA_SIZE-1:0] direction_reg;
    logic [PDATA_SIZE-1:0] out_reg;
    logic [PDATA_SIZE-1:0] irq_ena_reg;
    logic [PDATA_SIZE-1:0] tr_type_reg;
    logic [PDATA_SIZE-1:0] tr_pol_reg;
    logic [PDATA_SIZE-1:0] tr_status_reg;

    logic [SYNC_STAGES-1:0][PDATA_SIZE-1:0] sync_pipe;
    logic [PDATA_SIZE-1:0] in_sync;
    logic [PDATA_SIZE-1:0] in_prev;
    logic [PDATA_SIZE-1:0] rise;
    logic [PDATA_SIZE-1:0] fall;
    logic [PDATA_SIZE-1:0] hit;
    logic [PDATA_SIZE-1:0] w1c;
    logic [PDATA_SIZE-1:0] rdata;

    logic       undecoded;
    logic [2:0] reg_addr;
    logic       wr_en;
    logic       rd_setup;

    // Anything above the 8-register window is an error
    assign undecoded = (PADDR >> 3) != '0;
    assign reg_addr  = PADDR[2:0];
    assign wr_en     = PSEL & PENABLE & PWRITE & PSTRB & ~undecoded;
    assign rd_setup  = PSEL & ~PENABLE & ~PWRITE;

    assign PREADY  = 1'b1;
    assign PSLVERR = PSEL & PENABLE & undecoded;

    // Open-drain pins only ever pull low: enable the driver when the output is 0
    assign gpio_o  = out_reg & ~mode_reg;
    assign gpio_oe = direction_reg & ~(mode_reg & out_reg);

    assign in_sync = sync_pipe[SYNC_STAGES-1];
    assign rise    = in_sync & ~in_prev;
    assign fall    = ~in_sync & in_prev;
    assign w1c     = (wr_en && reg_addr == ADDR_TR_STATUS) ? PWDATA : '0;

    always_comb begin
        hit = '0;
        for (int i = 0; i < int'(PDATA_SIZE); i++) begin
            if (tr_type_reg[i]) hit[i] = tr_pol_reg[i] ? rise[i] : fall[i];
            else                hit[i] = tr_pol_reg[i] ? in_sync[i] : ~in_sync[i];
        end
        hit = hit & irq_ena_reg;
    end

    always_comb begin
        rdata = '0;
        case (reg_addr)
            ADDR_MODE:      rdata = mode_reg;
            ADDR_DIRECTION: rdata = direction_reg;
            ADDR_OUTPUT:    rdata = out_reg;
            ADDR_INPUT:     rdata = in_sync;
            ADDR_IRQ_ENA:   rdata = irq_ena_reg;
            ADDR_TR_TYPE:   rdata = tr_type_reg;
            ADDR_TR_POL:    rdata = tr_pol_reg;
            ADDR_TR_STATUS: rdata = tr_status_reg;
            default:        rdata = '0;
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            mode_reg      <= '0;
            direction_reg <= '0;
            out_reg       <= '0;
            irq_ena_reg   <= '0;
            tr_type_reg   <= '0;
            tr_pol_reg    <= '0;
        end else if (wr_en) begin
            case (reg_addr)
                ADDR_MODE:      mode_reg      <= PWDATA;
                ADDR_DIRECTION: direction_reg <= PWDATA;
                ADDR_OUTPUT:    out_reg       <= PWDATA;
                ADDR_IRQ_ENA:   irq_ena_reg   <= PWDATA;
                ADDR_TR_TYPE:   tr_type_reg   <= PWDATA;
                ADDR_TR_POL:    tr_pol_reg    <= PWDATA;
                default: ;
            endcase
        end
    end

    // Read data captured in the setup phase, held through the access phase
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) PRDATA <= '0;
        else if (rd_setup) PRDATA <= undecoded ? '0 : rdata;
    end

    // Input synchroniser, edge history, sticky status and registered irq
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            sync_pipe     <= '0;
            in_prev       <= '0;
            tr_status_reg <= '0;
            irq_o         <= 1'b0;
        end else begin
            sync_pipe     <= {sync_pipe[SYNC_STAGES-2:0], gpio_i};
            in_prev       <= in_sync;
            tr_status_reg <= hit | (tr_status_reg & ~w1c);
            irq_o         <= |tr_status_reg;
        end
    end

endmodule

// File: tb/tb_peripheral_gpio_apb4.sv
// Scoreboard bench for peripheral_gpio_apb4: stimulus queues expectations,
// a negedge monitor pops and compares on each read access or pad sample.
module tb_peripheral_gpio_apb4;

    logic       PCLK;
    logic       PRESET;
    logic       PSEL;
    logic       PENABLE;
    logic [3:0] PADDR;
    logic       PWRITE;
    logic       PSTRB;
    logic [7:0] PWDATA;
    logic [7:0] PRDATA;
    logic       PREADY;
    logic       PSLVERR;
    logic [7:0] gpio_i;
    logic [7:0] gpio_o;
    logic [7:0] gpio_oe;
    logic       irq_o;

    peripheral_gpio_apb4 #(.PADDR_SIZE(4), .PDATA_SIZE(8), .INPUT_STAGES(2)) dut (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE),
        .PADDR(PADDR), .PWRITE(PWRITE), .PSTRB(PSTRB), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .gpio_i(gpio_i), .gpio_o(gpio_o), .gpio_oe(gpio_oe), .irq_o(irq_o)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    typedef struct {
        string    name;
        bit       pin;
        logic [7:0] a;
        logic [7:0] b;
        logic       c;
    } exp_t;

    exp_t sb[$];
    logic pin_req;
    int   n_pass;
    int   n_total;
    exp_t e;

    // Monitor: a read access phase or a pad-sample request consumes one expectation
    always @(negedge PCLK) begin
        if ((PSEL && PENABLE && !PWRITE) || pin_req) begin
            n_total++;
            if (sb.size() == 0) begin
                $display("FAIL unqueued_event: DUT presented output with no expectation queued");
            end else begin
                e = sb.pop_front();
                if (e.pin) begin
                    if (gpio_o === e.a && gpio_oe === e.b && irq_o === e.c) n_pass++;
                    else $display("FAIL %s: gpio_o=%h gpio_oe=%h irq_o=%b, expected %h %h %b",
                                  e.name, gpio_o, gpio_oe, irq_o, e.a, e.b, e.c);
                end else begin
                    if (PSEL && PENABLE && !PWRITE && PREADY === 1'b1 &&
                        PRDATA === e.a && PSLVERR === e.c) n_pass++;
                    else $display("FAIL %s: PRDATA=%h PSLVERR=%b PREADY=%b, expected %h %b 1",
                                  e.name, PRDATA, PSLVERR, PREADY, e.a, e.c);
                end
            end
        end
    end

    task automatic step();
        @(posedge PCLK);
        #1;
    endtask

    task automatic apb_write(input logic [3:0] addr, input logic [7:0] data, input logic strb);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = addr; PWDATA = data; PSTRB = strb;
        step();
        PENABLE = 1'b1;
        step();
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PSTRB = 1'b0;
    endtask

    task automatic apb_read(input string name, input logic [3:0] addr,
                            input logic [7:0] data, input logic err);
        exp_t x;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = addr;
        step();
        x.name = name; x.pin = 1'b0; x.a = data; x.b = 8'h00; x.c = err;
        sb.push_back(x);
        PENABLE = 1'b1;
        step();
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic check_pins(input string name, input logic [7:0] o,
                              input logic [7:0] oe, input logic irq);
        exp_t x;
        x.name = name; x.pin = 1'b1; x.a = o; x.b = oe; x.c = irq;
        sb.push_back(x);
        pin_req = 1'b1;
        @(negedge PCLK);
        #1;
        pin_req = 1'b0;
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        n_pass = 0; n_total = 0; pin_req = 1'b0;
        PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PADDR = '0; PWRITE = 1'b0;
        PSTRB = 1'b0; PWDATA = '0; gpio_i = '0;
        repeat (3) step();
        PRESET = 1'b0;
        step();

        // Reset state and address decode
        check_pins("reset_pins", 8'h00, 8'h00, 1'b0);
        for (int a = 0; a < 8; a++) apb_read($sformatf("reset_rd%0d", a), 4'(a), 8'h00, 1'b0);
        apb_read("undecoded_rd", 4'h8, 8'h00, 1'b1);

        // Push-pull and open-drain pad drive
        apb_write(4'd1, 8'hFF, 1'b1);
        apb_write(4'd2, 8'hA5, 1'b1);
        check_pins("push_pull", 8'hA5, 8'hFF, 1'b0);
        apb_write(4'd0, 8'hFF, 1'b1);
        check_pins("open_drain", 8'h00, 8'h5A, 1'b0);
        apb_write(4'd0, 8'h00, 1'b1);
        check_pins("back_to_pp", 8'hA5, 8'hFF, 1'b0);
        apb_write(4'h8, 8'h33, 1'b1);
        apb_read("undecoded_wr_noeffect", 4'd0, 8'h00, 1'b0);

        // Input synchroniser latency, read-only INPUT, strobe-less write
        gpio_i = 8'h3C;
        apb_read("input_too_early", 4'd3, 8'h00, 1'b0);
        apb_read("input_synced", 4'd3, 8'h3C, 1'b0);
        apb_write(4'd3, 8'hFF, 1'b1);
        apb_read("input_ro", 4'd3, 8'h3C, 1'b0);
        apb_write(4'd2, 8'h00, 1'b0);
        apb_read("pstrb0_output", 4'd2, 8'hA5, 1'b0);
        check_pins("pstrb0_pins", 8'hA5, 8'hFF, 1'b0);

        // Rising-edge interrupt on bit 0 and its latency
        apb_write(4'd5, 8'h01, 1'b1);
        apb_write(4'd6, 8'h01, 1'b1);
        apb_write(4'd4, 8'h01, 1'b1);
        apb_read("status_idle", 4'd7, 8'h00, 1'b0);
        gpio_i = 8'h3D;
        repeat (3) step();
        check_pins("irq_not_yet", 8'hA5, 8'hFF, 1'b0);
        check_pins("irq_asserted", 8'hA5, 8'hFF, 1'b1);
        apb_read("status_rise", 4'd7, 8'h01, 1'b0);
        apb_write(4'd7, 8'h01, 1'b1);
        step();
        check_pins("irq_cleared", 8'hA5, 8'hFF, 1'b0);
        apb_read("status_w1c", 4'd7, 8'h00, 1'b0);

        // Level-high on bit 7 survives W1C; set beats a coincident clear
        apb_write(4'd6, 8'h81, 1'b1);
        apb_write(4'd4, 8'h81, 1'b1);
        gpio_i = 8'hBD;
        repeat (4) step();
        apb_read("level_set", 4'd7, 8'h80, 1'b0);
        check_pins("level_irq", 8'hA5, 8'hFF, 1'b1);
        apb_write(4'd7, 8'h80, 1'b1);
        apb_read("level_persists", 4'd7, 8'h80, 1'b0);
        gpio_i = 8'hBC;
        repeat (4) step();
        gpio_i = 8'hBD;
        step();
        apb_write(4'd7, 8'h01, 1'b1);
        apb_read("set_beats_clear", 4'd7, 8'h81, 1'b0);
        apb_write(4'd7, 8'h01, 1'b1);
        apb_read("edge_cleared", 4'd7, 8'h80, 1'b0);

        // Reset asserted during the access phase of a write
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 4'd2; PWDATA = 8'hFF; PSTRB = 1'b1;
        step();
        PENABLE = 1'b1;
        #2 PRESET = 1'b1;
        step();
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PSTRB = 1'b0;
        step();
        PRESET = 1'b0;
        step();
        check_pins("post_reset_pins", 8'h00, 8'h00, 1'b0);
        apb_read("post_reset_output", 4'd2, 8'h00, 1'b0);
        apb_read("post_reset_dir", 4'd1, 8'h00, 1'b0);
        apb_read("post_reset_status", 4'd7, 8'h00, 1'b0);
        repeat (2) step();

        n_total++;
        if (sb.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain: %0d expectations left, expected 0", sb.size());

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
